// File: rtl/id_exe_stage_if.sv
// Decode/EXE/WB-facing bundle of the ID/EXE pipeline register.
// master = environment (decode, memory, ALU, writeback); slave = id_exe_stage.
interface id_exe_stage_if;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_OPC_W = 4;

  // Decode side
  logic                 dec_valid;
  logic                 dec_ready;
  logic [ALU_OPC_W-1:0] dec_alu_opc;
  logic                 dec_sel_pc;
  logic [XLEN-1:0]      dec_pc;
  logic [REG_IDX_W-1:0] dec_rs1;
  logic [REG_IDX_W-1:0] dec_rs2;
  logic                 dec_rs1_used;
  logic                 dec_rs2_used;
  logic [XLEN-1:0]      dec_rs1_data;
  logic [XLEN-1:0]      dec_rs2_data;
  logic [XLEN-1:0]      dec_imm;
  logic                 dec_use_imm;
  logic [REG_IDX_W-1:0] dec_rd;
  logic                 dec_rd_wen;
  logic                 dec_is_load;

  // Pipeline control and forwarding sources
  logic                 flush;
  logic                 mem_ready;
  logic [XLEN-1:0]      alu_result;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 wb_wen;
  logic [XLEN-1:0]      wb_data;

  // Registered EXE payload
  logic                 exe_valid_r;
  logic [ALU_OPC_W-1:0] exe_alu_opc_r;
  logic                 exe_sel_pc_r;
  logic [XLEN-1:0]      exe_pc_r;
  logic [XLEN-1:0]      exe_reg1_r;
  logic [XLEN-1:0]      exe_src2_r;
  logic [XLEN-1:0]      exe_rs2_data_r;
  logic [REG_IDX_W-1:0] exe_rd_r;
  logic                 exe_rd_wen_r;
  logic                 exe_is_load_r;

  modport master (
    output dec_valid, dec_alu_opc, dec_sel_pc, dec_pc,
    output dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    output dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm,
    output dec_rd, dec_rd_wen, dec_is_load,
    output flush, mem_ready, alu_result, wb_rd, wb_wen, wb_data,
    input  dec_ready,
    input  exe_valid_r, exe_alu_opc_r, exe_sel_pc_r, exe_pc_r,
    input  exe_reg1_r, exe_src2_r, exe_rs2_data_r,
    input  exe_rd_r, exe_rd_wen_r, exe_is_load_r
  );

  modport slave (
    input  dec_valid, dec_alu_opc, dec_sel_pc, dec_pc,
    input  dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    input  dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm,
    input  dec_rd, dec_rd_wen, dec_is_load,
    input  flush, mem_ready, alu_result, wb_rd, wb_wen, wb_data,
    output dec_ready,
    output exe_valid_r, exe_alu_opc_r, exe_sel_pc_r, exe_pc_r,
    output exe_reg1_r, exe_src2_r, exe_rs2_data_r,
    output exe_rd_r, exe_rd_wen_r, exe_is_load_r
  );
endinterface

// File: rtl/id_exe_stage.sv
// RV32I decode-to-execute pipeline register with RAW hazard handling.
// Define FORWARDING_EN for EXE/WB bypassing; otherwise hazards stall until the producer leaves WB.
module id_exe_stage (
  input  logic          clk,
  input  logic          reset,
  id_exe_stage_if.slave bus
);
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_OPC_W = 4;

  logic                 exe_valid_q,    exe_valid_d;
  logic [ALU_OPC_W-1:0] exe_alu_opc_q,  exe_alu_opc_d;
  logic                 exe_sel_pc_q,   exe_sel_pc_d;
  logic [XLEN-1:0]      exe_pc_q,       exe_pc_d;
  logic [XLEN-1:0]      exe_reg1_q,     exe_reg1_d;
  logic [XLEN-1:0]      exe_src2_q,     exe_src2_d;
  logic [XLEN-1:0]      exe_rs2_data_q, exe_rs2_data_d;
  logic [REG_IDX_W-1:0] exe_rd_q,       exe_rd_d;
  logic                 exe_rd_wen_q,   exe_rd_wen_d;
  logic                 exe_is_load_q,  exe_is_load_d;

  logic            advance_c;
  logic            exe_hit1_c, exe_hit2_c;
  logic            wb_hit1_c, wb_hit2_c;
  logic            interlock_c;
  logic            dec_ready_c;
  logic            capture_c;
  logic [XLEN-1:0] fwd_rs1_c, fwd_rs2_c;

  assign advance_c = ~exe_valid_q | bus.mem_ready;

  // Register index 0 is hard-wired zero, so it never matches a producer.
  assign exe_hit1_c = exe_valid_q & exe_rd_wen_q & (exe_rd_q != '0) &
                      (bus.dec_rs1 == exe_rd_q) & bus.dec_rs1_used;
  assign exe_hit2_c = exe_valid_q & exe_rd_wen_q & (exe_rd_q != '0) &
                      (bus.dec_rs2 == exe_rd_q) & bus.dec_rs2_used;
  assign wb_hit1_c  = bus.wb_wen & (bus.wb_rd != '0) &
                      (bus.dec_rs1 == bus.wb_rd) & bus.dec_rs1_used;
  assign wb_hit2_c  = bus.wb_wen & (bus.wb_rd != '0) &
                      (bus.dec_rs2 == bus.wb_rd) & bus.dec_rs2_used;

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be bypassed; its data is not ready until WB.
  assign interlock_c = (exe_hit1_c | exe_hit2_c) & exe_is_load_q;

  // EXE is the younger producer, so it wins over WB.
  always_comb begin
    fwd_rs1_c = bus.dec_rs1_data;
    fwd_rs2_c = bus.dec_rs2_data;
    if (exe_hit1_c && !exe_is_load_q) begin
      fwd_rs1_c = bus.alu_result;
    end else if (wb_hit1_c) begin
      fwd_rs1_c = bus.wb_data;
    end
    if (exe_hit2_c && !exe_is_load_q) begin
      fwd_rs2_c = bus.alu_result;
    end else if (wb_hit2_c) begin
      fwd_rs2_c = bus.wb_data;
    end
  end
`else
  // Without bypass, wait until the register file holds the producer's value.
  assign interlock_c = exe_hit1_c | exe_hit2_c | wb_hit1_c | wb_hit2_c;
  assign fwd_rs1_c   = bus.dec_rs1_data;
  assign fwd_rs2_c   = bus.dec_rs2_data;

  logic unused_fwd_c;
  assign unused_fwd_c = ^{bus.alu_result, bus.wb_data};
`endif

  assign dec_ready_c = bus.flush | (advance_c & ~interlock_c);
  assign capture_c   = bus.dec_valid & dec_ready_c;

  // Next-state: flush, then hold, then capture, else bubble.
  always_comb begin
    exe_valid_d    = exe_valid_q;
    exe_alu_opc_d  = exe_alu_opc_q;
    exe_sel_pc_d   = exe_sel_pc_q;
    exe_pc_d       = exe_pc_q;
    exe_reg1_d     = exe_reg1_q;
    exe_src2_d     = exe_src2_q;
    exe_rs2_data_d = exe_rs2_data_q;
    exe_rd_d       = exe_rd_q;
    exe_rd_wen_d   = exe_rd_wen_q;
    exe_is_load_d  = exe_is_load_q;

    if (bus.flush) begin
      exe_valid_d   = 1'b0;
      exe_rd_wen_d  = 1'b0;
      exe_is_load_d = 1'b0;
    end else if (!advance_c) begin
      exe_valid_d = exe_valid_q;
    end else if (capture_c) begin
      exe_valid_d    = 1'b1;
      exe_alu_opc_d  = bus.dec_alu_opc;
      exe_sel_pc_d   = bus.dec_sel_pc;
      exe_pc_d       = bus.dec_pc;
      exe_reg1_d     = fwd_rs1_c;
      exe_src2_d     = bus.dec_use_imm ? bus.dec_imm : fwd_rs2_c;
      exe_rs2_data_d = fwd_rs2_c;
      exe_rd_d       = bus.dec_rd;
      exe_rd_wen_d   = bus.dec_rd_wen;
      exe_is_load_d  = bus.dec_is_load;
    end else begin
      exe_valid_d   = 1'b0;
      exe_rd_wen_d  = 1'b0;
      exe_is_load_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid_q    <= 1'b0;
      exe_alu_opc_q  <= '0;
      exe_sel_pc_q   <= 1'b0;
      exe_pc_q       <= '0;
      exe_reg1_q     <= '0;
      exe_src2_q     <= '0;
      exe_rs2_data_q <= '0;
      exe_rd_q       <= '0;
      exe_rd_wen_q   <= 1'b0;
      exe_is_load_q  <= 1'b0;
    end else begin
      exe_valid_q    <= exe_valid_d;
      exe_alu_opc_q  <= exe_alu_opc_d;
      exe_sel_pc_q   <= exe_sel_pc_d;
      exe_pc_q       <= exe_pc_d;
      exe_reg1_q     <= exe_reg1_d;
      exe_src2_q     <= exe_src2_d;
      exe_rs2_data_q <= exe_rs2_data_d;
      exe_rd_q       <= exe_rd_d;
      exe_rd_wen_q   <= exe_rd_wen_d;
      exe_is_load_q  <= exe_is_load_d;
    end
  end

  assign bus.dec_ready      = dec_ready_c;
  assign bus.exe_valid_r    = exe_valid_q;
  assign bus.exe_alu_opc_r  = exe_alu_opc_q;
  assign bus.exe_sel_pc_r   = exe_sel_pc_q;
  assign bus.exe_pc_r       = exe_pc_q;
  assign bus.exe_reg1_r     = exe_reg1_q;
  assign bus.exe_src2_r     = exe_src2_q;
  assign bus.exe_rs2_data_r = exe_rs2_data_q;
  assign bus.exe_rd_r       = exe_rd_q;
  assign bus.exe_rd_wen_r   = exe_rd_wen_q;
  assign bus.exe_is_load_r  = exe_is_load_q;
endmodule

// File: tb/tb_id_exe_stage.sv
// Directed testbench for id_exe_stage; expectations follow FORWARDING_EN if defined.
module tb_id_exe_stage;
  logic clk;
  logic reset;
  int   tests;
  int   failed;

  id_exe_stage_if bus ();

  id_exe_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    bus.dec_valid    = 1'b0;
    bus.dec_alu_opc  = 4'b0000;
    bus.dec_sel_pc   = 1'b0;
    bus.dec_pc       = 32'h0;
    bus.dec_rs1      = 5'd0;
    bus.dec_rs2      = 5'd0;
    bus.dec_rs1_used = 1'b0;
    bus.dec_rs2_used = 1'b0;
    bus.dec_rs1_data = 32'h0;
    bus.dec_rs2_data = 32'h0;
    bus.dec_imm      = 32'h0;
    bus.dec_use_imm  = 1'b0;
    bus.dec_rd       = 5'd0;
    bus.dec_rd_wen   = 1'b0;
    bus.dec_is_load  = 1'b0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic use_imm,
                           input logic wen, input logic is_load);
    bus.dec_valid    = 1'b1;
    bus.dec_alu_opc  = 4'b0000;
    bus.dec_sel_pc   = 1'b0;
    bus.dec_pc       = pc;
    bus.dec_rd       = rd;
    bus.dec_rs1      = rs1;
    bus.dec_rs2      = rs2;
    bus.dec_rs1_used = u1;
    bus.dec_rs2_used = u2;
    bus.dec_rs1_data = d1;
    bus.dec_rs2_data = d2;
    bus.dec_imm      = imm;
    bus.dec_use_imm  = use_imm;
    bus.dec_rd_wen   = wen;
    bus.dec_is_load  = is_load;
  endtask

  task automatic wb_idle;
    bus.wb_rd   = 5'd0;
    bus.wb_wen  = 1'b0;
    bus.wb_data = 32'h0;
  endtask

  task automatic drain;
    idle();
    wb_idle();
    bus.mem_ready = 1'b1;
    bus.flush     = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle();
    wb_idle();
    bus.flush      = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.alu_result = 32'h0;
    tick();
    tick();
    tests++; if (bus.exe_valid_r !== 1'b0) begin failed++; $display("FAIL reset_valid: got %0h want 0", bus.exe_valid_r); end
    tests++; if (bus.exe_alu_opc_r !== 4'b0000) begin failed++; $display("FAIL reset_opc: got %0h want 0", bus.exe_alu_opc_r); end
    tests++; if (bus.exe_pc_r !== 32'h0) begin failed++; $display("FAIL reset_pc: got %0h want 0", bus.exe_pc_r); end
    tests++; if (bus.exe_rd_wen_r !== 1'b0) begin failed++; $display("FAIL reset_wen: got %0h want 0", bus.exe_rd_wen_r); end
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %0h want 1", bus.dec_ready); end
  endtask

  task automatic test_forward_alu;
    // addi x1,x0,5
    set_instr(32'h100, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h5, 1'b1, 1'b1, 1'b0);
    settle();
    tick();
    tests++; if (bus.exe_src2_r !== 32'h5) begin failed++; $display("FAIL addi_src2: got %0h want 5", bus.exe_src2_r); end
    // add x2,x1,x1 with stale register-file data
    bus.alu_result = 32'h5;
    set_instr(32'h104, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    settle();
`ifdef FORWARDING_EN
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL fwd_ready: got %0h want 1", bus.dec_ready); end
    tick();
`else
    tests++; if (bus.dec_ready !== 1'b0) begin failed++; $display("FAIL nofwd_stall1: got %0h want 0", bus.dec_ready); end
    tick();
    tests++; if (bus.exe_valid_r !== 1'b0) begin failed++; $display("FAIL nofwd_bubble1: got %0h want 0", bus.exe_valid_r); end
    bus.wb_rd = 5'd1; bus.wb_wen = 1'b1; bus.wb_data = 32'h5;
    settle();
    tests++; if (bus.dec_ready !== 1'b0) begin failed++; $display("FAIL nofwd_stall2: got %0h want 0", bus.dec_ready); end
    tick();
    tests++; if (bus.exe_valid_r !== 1'b0) begin failed++; $display("FAIL nofwd_bubble2: got %0h want 0", bus.exe_valid_r); end
    wb_idle();
    bus.dec_rs1_data = 32'h5;
    bus.dec_rs2_data = 32'h5;
    settle();
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL nofwd_release: got %0h want 1", bus.dec_ready); end
    tick();
`endif
    tests++; if (bus.exe_valid_r !== 1'b1) begin failed++; $display("FAIL add_valid: got %0h want 1", bus.exe_valid_r); end
    tests++; if (bus.exe_reg1_r !== 32'h5) begin failed++; $display("FAIL add_reg1: got %0h want 5", bus.exe_reg1_r); end
    tests++; if (bus.exe_src2_r !== 32'h5) begin failed++; $display("FAIL add_src2: got %0h want 5", bus.exe_src2_r); end
    tests++; if (bus.exe_pc_r !== 32'h104) begin failed++; $display("FAIL add_pc: got %0h want 104", bus.exe_pc_r); end
    drain();
  endtask

  task automatic test_load_use;
    // lw x3,0x100(x0)
    set_instr(32'h140, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h100, 1'b1, 1'b1, 1'b1);
    tick();
    tests++; if (bus.exe_is_load_r !== 1'b1) begin failed++; $display("FAIL lw_isload: got %0h want 1", bus.exe_is_load_r); end
    // add x4,x3,x0
    set_instr(32'h144, 5'd4, 5'd3, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    settle();
    tests++; if (bus.dec_ready !== 1'b0) begin failed++; $display("FAIL lu_ready: got %0h want 0", bus.dec_ready); end
    tick();
    tests++; if (bus.exe_valid_r !== 1'b0) begin failed++; $display("FAIL lu_bubble: got %0h want 0", bus.exe_valid_r); end
    tests++; if (bus.exe_rd_wen_r !== 1'b0) begin failed++; $display("FAIL lu_bubble_wen: got %0h want 0", bus.exe_rd_wen_r); end
    bus.wb_rd = 5'd3; bus.wb_wen = 1'b1; bus.wb_data = 32'hDEADBEEF;
    settle();
`ifdef FORWARDING_EN
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL lu_accept: got %0h want 1", bus.dec_ready); end
    tick();
`else
    tests++; if (bus.dec_ready !== 1'b0) begin failed++; $display("FAIL lu_wb_stall: got %0h want 0", bus.dec_ready); end
    tick();
    wb_idle();
    bus.dec_rs1_data = 32'hDEADBEEF;
    tick();
`endif
    tests++; if (bus.exe_valid_r !== 1'b1) begin failed++; $display("FAIL lu_valid: got %0h want 1", bus.exe_valid_r); end
    tests++; if (bus.exe_reg1_r !== 32'hDEADBEEF) begin failed++; $display("FAIL lu_reg1: got %0h want deadbeef", bus.exe_reg1_r); end
    tests++; if (bus.exe_src2_r !== 32'h0) begin failed++; $display("FAIL lu_src2: got %0h want 0", bus.exe_src2_r); end
    drain();
  endtask

  task automatic test_store_payload;
    set_instr(32'h180, 5'd0, 5'd20, 5'd21, 1'b1, 1'b1, 32'h1000, 32'hCAFE, 32'h8, 1'b1, 1'b0, 1'b0);
    bus.dec_alu_opc = 4'b1000;
    bus.dec_sel_pc  = 1'b1;
    tick();
    tests++; if (bus.exe_src2_r !== 32'h8) begin failed++; $display("FAIL st_src2: got %0h want 8", bus.exe_src2_r); end
    tests++; if (bus.exe_rs2_data_r !== 32'hCAFE) begin failed++; $display("FAIL st_rs2data: got %0h want cafe", bus.exe_rs2_data_r); end
    tests++; if (bus.exe_reg1_r !== 32'h1000) begin failed++; $display("FAIL st_reg1: got %0h want 1000", bus.exe_reg1_r); end
    tests++; if (bus.exe_alu_opc_r !== 4'b1000) begin failed++; $display("FAIL st_opc: got %0h want 8", bus.exe_alu_opc_r); end
    tests++; if (bus.exe_sel_pc_r !== 1'b1) begin failed++; $display("FAIL st_selpc: got %0h want 1", bus.exe_sel_pc_r); end
    drain();
  endtask

  task automatic test_backpressure;
    set_instr(32'h200, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.mem_ready = 1'b0;
    set_instr(32'h204, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 32'h33, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      tests++; if (bus.dec_ready !== 1'b0) begin failed++; $display("FAIL bp_ready[%0d]: got %0h want 0", i, bus.dec_ready); end
      tick();
      tests++; if (bus.exe_pc_r !== 32'h200 || bus.exe_reg1_r !== 32'h11 || bus.exe_valid_r !== 1'b1)
        begin failed++; $display("FAIL bp_hold[%0d]: got pc %0h reg1 %0h v %0h want 200 11 1", i, bus.exe_pc_r, bus.exe_reg1_r, bus.exe_valid_r); end
    end
    bus.mem_ready = 1'b1;
    settle();
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL bp_release: got %0h want 1", bus.dec_ready); end
    tick();
    tests++; if (bus.exe_pc_r !== 32'h204 || bus.exe_reg1_r !== 32'h33)
      begin failed++; $display("FAIL bp_next: got pc %0h reg1 %0h want 204 33", bus.exe_pc_r, bus.exe_reg1_r); end
    drain();
  endtask

  task automatic test_flush;
    set_instr(32'h300, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.mem_ready = 1'b0;
    bus.flush     = 1'b1;
    set_instr(32'h304, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    settle();
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL fl_ready: got %0h want 1", bus.dec_ready); end
    tick();
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;
    idle();
    tests++; if (bus.exe_valid_r !== 1'b0) begin failed++; $display("FAIL fl_valid: got %0h want 0", bus.exe_valid_r); end
    tests++; if (bus.exe_rd_wen_r !== 1'b0) begin failed++; $display("FAIL fl_wen: got %0h want 0", bus.exe_rd_wen_r); end
    tick();
    tests++; if (bus.exe_valid_r !== 1'b0 || bus.exe_pc_r === 32'h304)
      begin failed++; $display("FAIL fl_dropped: got v %0h pc %0h want 0 and pc not 304", bus.exe_valid_r, bus.exe_pc_r); end
    drain();
  endtask

  task automatic test_x0;
    // add x0,x1,x1
    set_instr(32'h400, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 32'h55, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.alu_result = 32'hAA;
    bus.wb_rd = 5'd0; bus.wb_wen = 1'b1; bus.wb_data = 32'h1234;
    // add x5,x0,x0
    set_instr(32'h404, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    settle();
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL x0_ready: got %0h want 1", bus.dec_ready); end
    tick();
    tests++; if (bus.exe_reg1_r !== 32'h0) begin failed++; $display("FAIL x0_reg1: got %0h want 0", bus.exe_reg1_r); end
    tests++; if (bus.exe_src2_r !== 32'h0) begin failed++; $display("FAIL x0_src2: got %0h want 0", bus.exe_src2_r); end
    drain();
  endtask

  task automatic test_exe_wb_priority;
    set_instr(32'h500, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.alu_result = 32'h7;
    bus.wb_rd = 5'd6; bus.wb_wen = 1'b1; bus.wb_data = 32'h9;
    set_instr(32'h504, 5'd7, 5'd6, 5'd6, 1'b1, 1'b1, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
    settle();
`ifdef FORWARDING_EN
    tests++; if (bus.dec_ready !== 1'b1) begin failed++; $display("FAIL prio_ready: got %0h want 1", bus.dec_ready); end
    tick();
`else
    tests++; if (bus.dec_ready !== 1'b0) begin failed++; $display("FAIL prio_stall: got %0h want 0", bus.dec_ready); end
    tick();
    bus.wb_data = 32'h7;
    tick();
    wb_idle();
    bus.dec_rs1_data = 32'h7;
    bus.dec_rs2_data = 32'h7;
    tick();
`endif
    tests++; if (bus.exe_reg1_r !== 32'h7) begin failed++; $display("FAIL prio_reg1: got %0h want 7", bus.exe_reg1_r); end
    tests++; if (bus.exe_src2_r !== 32'h7) begin failed++; $display("FAIL prio_src2: got %0h want 7", bus.exe_src2_r); end
    drain();
  endtask

  task automatic test_reset_during_stall;
    set_instr(32'h600, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (bus.exe_valid_r !== 1'b0 || bus.exe_pc_r !== 32'h0 || bus.exe_rd_wen_r !== 1'b0)
      begin failed++; $display("FAIL rst_stall: got v %0h pc %0h wen %0h want 0 0 0", bus.exe_valid_r, bus.exe_pc_r, bus.exe_rd_wen_r); end
    drain();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_forward_alu();
    test_load_use();
    test_store_payload();
    test_backpressure();
    test_flush();
    test_x0();
    test_exe_wb_priority();
    test_reset_during_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
